spi_frame_rx: RTL

Oversampling SPI receiver that captures the 24-bit LSB-first frames produced by the XPU RF-switch/LO SPI master and presents each frame as a parallel word with a valid/ready handshake. It sits in the XPU as a loopback monitor on the shared `spi_sclk`/`spi_csn`/`spi_mosi` lines. It lets firmware and testbenches confirm which control word (Tx-high or Tx-low pattern) actually reached the radio. All SPI inputs are treated as asynchronous and sampled in the `clk` domain.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_frame_rx_if.sv | 26 ++
 rtl/spi_in_sync.sv | 51 +++++
 rtl/spi_frame_rx.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants and FSM state type used by the XPU SPI master and the
// loopback receiver, so both sides agree on the frame length and control words.
package spi_pkg;

  localparam int SPI_DATA_LENGTH = 24;

  localparam logic [SPI_DATA_LENGTH-1:0] SPI_HIGH = 24'hAAAAAA;
  localparam logic [SPI_DATA_LENGTH-1:0] SPI_LOW  = 24'h555555;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_CHECK = 2'b11
  } spi_rx_state_e;

endpackage

// File: rtl/spi_frame_rx_if.sv
// Parallel frame output of spi_frame_rx: valid/ready word stream plus status flags.
// The receiver drives it through the master modport; the consumer uses slave.
interface spi_frame_rx_if import spi_pkg::*; #(
  parameter int DATA_LENGTH = SPI_DATA_LENGTH
) ();

  logic [DATA_LENGTH-1:0] rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic                   rx_len_err;
  logic                   rx_overflow;
  logic                   rx_busy;
  logic                   rx_is_high;
  logic                   rx_is_low;

  modport master (
    output rx_data, rx_valid, rx_len_err, rx_overflow, rx_busy, rx_is_high, rx_is_low,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, rx_len_err, rx_overflow, rx_busy, rx_is_high, rx_is_low,
    output rx_ready
  );

endinterface

// File: rtl/spi_in_sync.sv
// SYNC_FF-deep synchronizer for one asynchronous SPI line, followed by a level
// flop and registered rise/fall pulses. RST_VAL is the idle level of the line.
module spi_in_sync #(
  parameter int   SYNC_FF = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_FF-1:0] sync_q, sync_d;
  logic [SYNC_FF:0]   seen_q, seen_d;
  logic               level_q, level_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;

  // seen_q marks stages holding a real sample rather than the reset value, so a
  // line that is already away from its idle level at reset release is not an edge.
  always_comb begin
    sync_d  = {sync_q[SYNC_FF-2:0], din};
    seen_d  = {seen_q[SYNC_FF-1:0], 1'b1};
    level_d = sync_q[SYNC_FF-1];
    rise_d  = seen_q[SYNC_FF] &  sync_q[SYNC_FF-1] & ~level_q;
    fall_d  = seen_q[SYNC_FF] & ~sync_q[SYNC_FF-1] &  level_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= {SYNC_FF{RST_VAL}};
      seen_q  <= '0;
      level_q <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      seen_q  <= seen_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout = level_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_frame_rx.sv
// Oversampling LSB-first SPI frame receiver with valid/ready output.
// Define SPI_RX_DECODE_EN to build the SPI_HIGH/SPI_LOW word decoders.
module spi_frame_rx import spi_pkg::*; #(
  parameter int DATA_LENGTH = SPI_DATA_LENGTH,
  parameter int SYNC_FF     = 2   // legal range 2..4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           spi_sclk,
  input  logic           spi_csn,
  input  logic           spi_mosi,
  spi_frame_rx_if.master rx
);

  localparam int               CNT_W    = $clog2(DATA_LENGTH + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_LENGTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_LENGTH + 1);

  logic sclk_fall, csn_rise, csn_fall, mosi_s;
  logic sclk_dout_unused, sclk_rise_unused, csn_dout_unused;
  logic mosi_rise_unused, mosi_fall_unused;

  spi_in_sync #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rstn(rstn), .din(spi_sclk),
    .dout(sclk_dout_unused), .rise(sclk_rise_unused), .fall(sclk_fall)
  );

  spi_in_sync #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rstn(rstn), .din(spi_csn),
    .dout(csn_dout_unused), .rise(csn_rise), .fall(csn_fall)
  );

  spi_in_sync #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rstn(rstn), .din(spi_mosi),
    .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_rx_state_e          state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_LENGTH-1:0] shift_q, shift_d;
  logic [DATA_LENGTH-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   len_err_q, len_err_d;
  logic                   overflow_q, overflow_d;
  logic                   load;

  assign load = (state_q == ST_CHECK) && (bit_cnt_q == CNT_FULL) &&
                (!valid_q || rx.rx_ready);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q;
    len_err_d  = 1'b0;
    overflow_d = overflow_q;

    if (valid_q && rx.rx_ready) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (csn_fall) begin
          state_d = ST_SHIFT;
          shift_d = '0;
        end
      end
      ST_SHIFT: begin
        // A coincident csn rise still lets this cycle's bit land before CHECK.
        if (sclk_fall) begin
          for (int i = 0; i < DATA_LENGTH; i++) begin
            if (bit_cnt_q == CNT_W'(i)) shift_d[i] = mosi_s;
          end
          if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (csn_rise) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (bit_cnt_q != CNT_FULL) begin
          len_err_d = 1'b1;
        end else if (load) begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      len_err_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      len_err_q  <= len_err_d;
      overflow_q <= overflow_d;
    end
  end

  assign rx.rx_data     = data_q;
  assign rx.rx_valid    = valid_q;
  assign rx.rx_len_err  = len_err_q;
  assign rx.rx_overflow = overflow_q;
  assign rx.rx_busy     = (state_q == ST_SHIFT);

`ifdef SPI_RX_DECODE_EN
  logic is_high_q, is_high_d, is_low_q, is_low_d;

  always_comb begin
    is_high_d = is_high_q;
    is_low_d  = is_low_q;
    if (load) begin
      is_high_d = (shift_q == DATA_LENGTH'(SPI_HIGH));
      is_low_d  = (shift_q == DATA_LENGTH'(SPI_LOW));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      is_high_q <= 1'b0;
      is_low_q  <= 1'b0;
    end else begin
      is_high_q <= is_high_d;
      is_low_q  <= is_low_d;
    end
  end

  assign rx.rx_is_high = is_high_q;
  assign rx.rx_is_low  = is_low_q;
`else
  assign rx.rx_is_high = 1'b0;
  assign rx.rx_is_low  = 1'b0;
`endif

endmodule
